// File: rtl/mixcolumns_pipe.sv
// mixcolumns_pipe: two-stage AES MixColumns with last-round bypass and sideband tag.
// Define MIXCOLUMNS_INV_EN to add the inv input selecting InvMixColumns.
module mixcolumns_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  input  logic             last_in,
`ifdef MIXCOLUMNS_INV_EN
  input  logic             inv,
`endif
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out,
  output logic             last_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [15:0]      blk_count
);
  typedef logic [15:0][7:0] st_t;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // coefficient for a_j in row i, indexed by (j - i) mod 4
  function automatic logic [3:0] cf(input logic iv, input logic [1:0] d);
    return iv ? (d == 2'd0 ? 4'he : d == 2'd1 ? 4'hb : d == 2'd2 ? 4'hd : 4'h9)
              : (d == 2'd0 ? 4'h2 : d == 2'd1 ? 4'h3 : 4'h1);
  endfunction
  function automatic logic [7:0] gm(input logic [3:0] k, input logic [7:0] b1, input logic [7:0] b2,
                                    input logic [7:0] b4, input logic [7:0] b8);
    return ({8{k[0]}} & b1) ^ ({8{k[1]}} & b2) ^ ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
  endfunction
  st_t din, mix, m4, m8;
  st_t s1_b_q, s1_b_d, s1_x2_q, s1_x2_d, data_out_q, data_out_d;
  logic en, inv_s;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, out_valid_q, out_valid_d, last_out_q, last_out_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, tag_out_q, tag_out_d;
  logic [15:0] blk_count_q, blk_count_d;
`ifdef MIXCOLUMNS_INV_EN
  st_t s1_x4_q, s1_x4_d, s1_x8_q, s1_x8_d;
  logic s1_inv_q, s1_inv_d;
  assign m4 = s1_x4_q;
  assign m8 = s1_x8_q;
  assign inv_s = s1_inv_q;
  always_comb begin
    s1_inv_d = en ? inv : s1_inv_q;
    s1_x4_d = s1_x4_q;
    s1_x8_d = s1_x8_q;
    for (int k = 0; k < 16; k++) begin
      s1_x4_d[k] = en ? xt(xt(din[k])) : s1_x4_q[k];
      s1_x8_d[k] = en ? xt(xt(xt(din[k]))) : s1_x8_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_inv_q <= 1'b0;
      s1_x4_q <= '0;
      s1_x8_q <= '0;
    end else begin
      s1_inv_q <= s1_inv_d;
      s1_x4_q <= s1_x4_d;
      s1_x8_q <= s1_x8_d;
    end
  end
`else
  assign m4 = '0;
  assign m8 = '0;
  assign inv_s = 1'b0;
`endif
  assign din = data_in;
  assign en = !out_valid_q | out_ready;
  assign in_ready = en;
  always_comb begin
    s1_valid_d = en ? in_valid : s1_valid_q;
    s1_last_d = en ? last_in : s1_last_q;
    s1_tag_d = en ? tag_in : s1_tag_q;
    s1_b_d = en ? din : s1_b_q;
    s1_x2_d = s1_x2_q;
    for (int k = 0; k < 16; k++) s1_x2_d[k] = en ? xt(din[k]) : s1_x2_q[k];
  end
  // byte n of the state (column n/4, row n%4) sits at packed index 15-n
  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          mix[15-4*c-i] = mix[15-4*c-i] ^ gm(cf(inv_s, 2'(j - i)), s1_b_q[15-4*c-j],
                                             s1_x2_q[15-4*c-j], m4[15-4*c-j], m8[15-4*c-j]);
  end
  always_comb begin
    out_valid_d = en ? s1_valid_q : out_valid_q;
    data_out_d = en ? (s1_last_q ? s1_b_q : mix) : data_out_q;
    last_out_d = en ? s1_last_q : last_out_q;
    tag_out_d = en ? s1_tag_q : tag_out_q;
    blk_count_d = blk_count_q + {15'd0, out_valid_q & out_ready};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_tag_q <= '0;
      s1_b_q <= '0;
      s1_x2_q <= '0;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
      last_out_q <= 1'b0;
      tag_out_q <= '0;
      blk_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_tag_q <= s1_tag_d;
      s1_b_q <= s1_b_d;
      s1_x2_q <= s1_x2_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
      last_out_q <= last_out_d;
      tag_out_q <= tag_out_d;
      blk_count_q <= blk_count_d;
    end
  end
  assign out_valid = out_valid_q;
  assign data_out = data_out_q;
  assign last_out = last_out_q;
  assign tag_out = tag_out_q;
  assign blk_count = blk_count_q;
endmodule

// File: doc/mixcolumns_pipe.md
MIXCOLUMNS_PIPE -- requirements
Module: mixcolumns_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the sideband tag (round index) carried alongside each state.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream (ShiftRows stage) state valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a state this cycle.
REQ-006 SHALL have port data_in, input, 128 bits: AES state after ShiftRows.
  - Column-major layout; byte 0 at [127:120].
  - Column c occupies [127-32c : 96-32c], row 0 at its MSB.
REQ-007 SHALL have port last_in, input, 1 bit: final round; MixColumns bypassed.
REQ-008 SHALL have port tag_in, input, TAG_W bits: sideband tag, passed through unchanged.
REQ-009 SHALL have port out_valid, output, 1 bit: data_out/last_out/tag_out valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream (AddRoundKey) accepts.
REQ-011 SHALL have port data_out, output, 128 bits: mixed (or bypassed) state, same layout as data_in.
REQ-012 SHALL have ports last_out (1 bit) and tag_out (TAG_W bits), outputs: values accompanying data_out.
REQ-013 SHALL have port blk_count, output, 16 bits: number of states delivered at the output since reset.

Function
REQ-014 SHALL be a two-stage pipeline with fixed latency of 2 cycles from accepted input to out_valid, absent stalls.
REQ-015 Stage 1 SHALL register, per byte, the input byte and xtime(byte).
  - xtime: shift left 1; XOR 0x1B if the input MSB was 1.
  - last/tag/valid SHALL be registered alongside.
REQ-016 Stage 2 SHALL register the column results per FIPS-197:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 3x is computed as xtime(x)^x.
REQ-017 When the stage-1 last flag is 1, stage 2 SHALL load the unmodified stage-1 state.
REQ-018 Pipeline advance enable SHALL be en = !out_valid | out_ready.
  - in_ready SHALL equal en; it is combinational from out_valid and out_ready only.
REQ-019 A transfer SHALL occur only when in_valid & in_ready; stage 1 valid loads in_valid & en.
REQ-020 When en=0, both stages SHALL hold data, last, tag and valid unchanged (full stall; no bubble squeeze).
REQ-021 While out_valid=1 and out_ready=0, data_out, last_out and tag_out SHALL remain stable.
REQ-022 Simultaneous output transfer and input acceptance SHALL sustain one state per cycle throughput.
REQ-023 blk_count SHALL increment by 1 on each cycle with out_valid & out_ready, and wrap 0xFFFF -> 0x0000.
REQ-024 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages without stopping valid states behind them.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL clear:
  - both stage valid flags, so out_valid=0;
  - data_out, last_out, tag_out and blk_count to 0;
  - stage-1 data to 0.
REQ-026 Reset mid-operation SHALL discard in-flight states; no discarded state may later appear at the output.
REQ-027 in_ready SHALL be 1 during the cycle after reset, because out_valid=0.

Configuration
REQ-028 With macro MIXCOLUMNS_INV_EN defined, the block SHALL add input inv (1 bit), registered with each state.
  - When inv=1 (and last=0), stage 2 SHALL compute InvMixColumns: coefficients {0e,0b,0d,09} rotated per row.
  - Stage 1 SHALL additionally register x4 and x8 multiples.
  - Latency SHALL remain 2.
REQ-029 Without MIXCOLUMNS_INV_EN, port inv and the x4/x8 logic SHALL be absent; behaviour is forward only.

Verification
REQ-030 Column db 13 53 45 in all four columns, last=0, tag=5 -> after 2 cycles every column 8e 4d a1 bc, tag_out=5, blk_count=1.
REQ-031 Columns f2 0a 22 5c / 01 01 01 01 / c6 c6 c6 c6 / d4 d4 d4 d5 -> 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6 / d5 d5 d7 d6.
REQ-032 Same stimulus as REQ-031 with last=1 -> data_out equals data_in bit-exact; last_out=1.
REQ-033 Stall and reset sequence:
  - Stream 4 states back-to-back with out_ready=0 from cycle 3 -> out_valid held, data_out stable, in_ready=0, no state lost or duplicated.
  - Release out_ready -> all 4 delivered in order.
  - Then assert rst with 2 states in flight -> out_valid=0 next cycle; none delivered; blk_count=0.
REQ-034 blk_count wrap: preload via 65535 transfers, deliver 1 more -> blk_count=0x0000.
REQ-035 With MIXCOLUMNS_INV_EN: column 8e 4d a1 bc with inv=1 -> db 13 53 45 after 2 cycles.
